// File: rtl/bitstream_pkg.sv
// Shared widths, types and helpers for the SRAM bitstream reader and its bit buffer.
package bitstream_pkg;

    localparam int BUF_W_DEFAULT = 64;
    localparam int WIN_W_DEFAULT = 32;
    localparam int WORD_W        = 16;
    localparam int ADDR_W        = 18;
    localparam int FILL_W        = $clog2(BUF_W_DEFAULT + 1);
    localparam int CNT_W         = $clog2(WIN_W_DEFAULT + 1);

    typedef logic [FILL_W-1:0] fill_t;
    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rd_state_e;

    function automatic int count_ones(input logic [15:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 16; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

// File: rtl/bit_shift_buffer.sv
// Left-justified bit FIFO: oldest bit sits at the MSB, new words are appended directly
// behind the valid bits after any same-cycle consume.
module bit_shift_buffer
    import bitstream_pkg::*;
#(
    parameter int BUF_W = BUF_W_DEFAULT,
    parameter int WIN_W = WIN_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             consume_i,
    input  cnt_t             consume_n_i,
    input  logic             append_en_i,
    input  word_t            append_word_i,
    output logic [WIN_W-1:0] win_o,
    output fill_t            fill_o,
    output fill_t            fill_pc_o,
    output logic             underflow_o
);

    logic [BUF_W-1:0] buf_q, buf_d, shifted;
    fill_t            fill_q, fill_d, fill_pc;
    logic             underflow_q, underflow_d;

    always_comb begin
        shifted     = buf_q;
        fill_pc     = fill_q;
        underflow_d = underflow_q;
        if (consume_i && (consume_n_i != '0)) begin
            if (FILL_W'(consume_n_i) > fill_q) begin
                // Over-consume drains everything so bits below fill stay zero.
                shifted     = '0;
                fill_pc     = '0;
                underflow_d = 1'b1;
            end else begin
                shifted = buf_q << consume_n_i;
                fill_pc = fill_q - FILL_W'(consume_n_i);
            end
        end

        buf_d  = shifted;
        fill_d = fill_pc;
        if (append_en_i) begin
            buf_d  = shifted | ({append_word_i, {(BUF_W - WORD_W){1'b0}}} >> fill_pc);
            fill_d = fill_pc + FILL_W'(WORD_W);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            buf_q       <= '0;
            fill_q      <= '0;
            underflow_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (int'(fill_q) <= BUF_W);
    end

    assign win_o       = buf_q[BUF_W-1 -: WIN_W];
    assign fill_o      = fill_q;
    assign fill_pc_o   = fill_pc;
    assign underflow_o = underflow_q;

endmodule

// File: rtl/sram_bitstream_reader.sv
// Streams sequential 16-bit SRAM words into an MSB-first peek window for the M3 decoder.
// Owns the read address counter, the in-flight tag pipe and the read issue rule.
module sram_bitstream_reader
    import bitstream_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int BUF_W        = BUF_W_DEFAULT,
    parameter int WIN_W        = WIN_W_DEFAULT
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             start,
    input  addr_t            base_address,
    input  logic             enable,
    input  word_t            SRAM_read_data,
    input  logic             consume,
    input  cnt_t             consume_n,
    output addr_t            SRAM_address,
    output logic             SRAM_we_n,
    output logic [WIN_W-1:0] window,
    output logic             window_valid,
    output fill_t            fill,
    output addr_t            words_read,
    output logic             underflow_err
);

    rd_state_e               state_q, state_d;
    addr_t                   addr_q, addr_d;
    addr_t                   words_q, words_d;
    logic [READ_LATENCY-1:0] tag_q, tag_d;
    logic                    issue, arrive;
    int                      inflight;
    fill_t                   fill_w, fill_pc;

    assign arrive = tag_q[READ_LATENCY-1];

    always_comb begin
        inflight = count_ones(16'(tag_q));
        // Budget against the post-consume fill so a 16-bit/cycle consumer never starves.
        issue = (state_q == S_STREAM) && enable && !start &&
                ((int'(fill_pc) + WORD_W * (inflight + 1)) <= BUF_W);

        state_d  = state_q;
        tag_d    = tag_q << 1;
        tag_d[0] = issue;
        addr_d   = issue  ? addr_q + ADDR_W'(1)  : addr_q;
        words_d  = arrive ? words_q + ADDR_W'(1) : words_q;

        if (start) begin
            // Clearing the tags drops every read issued before the restart.
            state_d = S_STREAM;
            addr_d  = base_address;
            tag_d   = '0;
            words_d = '0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            tag_q   <= '0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
            words_q <= words_d;
        end
    end

    bit_shift_buffer #(
        .BUF_W(BUF_W),
        .WIN_W(WIN_W)
    ) u_buf (
        .clk_i        (Clock),
        .rst_i        (Reset),
        .flush_i      (start),
        .consume_i    (consume),
        .consume_n_i  (consume_n),
        .append_en_i  (arrive),
        .append_word_i(SRAM_read_data),
        .win_o        (window),
        .fill_o       (fill_w),
        .fill_pc_o    (fill_pc),
        .underflow_o  (underflow_err)
    );

    assign SRAM_address = addr_q;
    assign SRAM_we_n    = 1'b1;
    assign fill         = fill_w;
    assign window_valid = (fill_w >= FILL_W'(WIN_W));
    assign words_read   = words_q;

endmodule

// File: tb/tb_sram_bitstream_reader.sv
// Bench for sram_bitstream_reader: 2-cycle SRAM model returning address[15:0], vector
// table for pure-shift consumes, scoreboard for streaming, hand sequences for corners.
module tb_sram_bitstream_reader;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic [17:0] base_address;
    logic        enable;
    logic [15:0] SRAM_read_data;
    logic        consume;
    logic [5:0]  consume_n;
    logic [17:0] SRAM_address;
    logic        SRAM_we_n;
    logic [31:0] window;
    logic        window_valid;
    logic [6:0]  fill;
    logic [17:0] words_read;
    logic        underflow_err;

    sram_bitstream_reader dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .start         (start),
        .base_address  (base_address),
        .enable        (enable),
        .SRAM_read_data(SRAM_read_data),
        .consume       (consume),
        .consume_n     (consume_n),
        .SRAM_address  (SRAM_address),
        .SRAM_we_n     (SRAM_we_n),
        .window        (window),
        .window_valid  (window_valid),
        .fill          (fill),
        .words_read    (words_read),
        .underflow_err (underflow_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // SRAM: data for the address presented in cycle t is visible in cycle t+2.
    logic [17:0] sram_d1, sram_d2;
    always @(posedge Clock) begin
        sram_d1 <= SRAM_address;
        sram_d2 <= sram_d1;
    end
    assign SRAM_read_data = sram_d2[15:0];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_start(input logic [17:0] base);
        base_address = base;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_addr", 64'(SRAM_address), 64'(base));
        check("start_fill", 64'(fill), 64'd0);
        check("start_words", 64'(words_read), 64'd0);
        check("start_uf", 64'(underflow_err), 64'd0);
    endtask

    task automatic prime(input logic [17:0] base);
        int n;
        enable = 1'b1;
        do_start(base);
        n = 0;
        while (fill != 7'd64 && n < 30) begin
            step();
            n++;
        end
        check("prime_fill", 64'(fill), 64'd64);
    endtask

    task automatic wait_valid(input string name, input int exp_lat);
        int lat;
        lat = 0;
        while (!window_valid && lat < 20) begin
            step();
            lat++;
        end
        check(name, 64'(lat), 64'(exp_lat));
    endtask

    // Streaming scoreboard: expected head words queued as each consume is driven.
    logic [15:0] sb_q[$];
    logic        sb_en;

    always @(negedge Clock) begin
        if (sb_en && consume) begin
            check("tp_valid", 64'(window_valid), 64'd1);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tp_word: got 0x%0h, expected queue empty", window[31:16]);
            end else begin
                check("tp_word", 64'(window[31:16]), 64'(sb_q.pop_front()));
            end
        end
    end

    typedef struct {
        logic [5:0]  n;
        logic [6:0]  exp_fill;
        logic [31:0] exp_win;
        logic        exp_vld;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Buffer after priming at 0x100: 0x0100_0101_0102_0103, enable held low.
        vecs[0] = '{6'd0,  7'd64, 32'h01000101, 1'b1, 1'b0};
        vecs[1] = '{6'd4,  7'd60, 32'h10001010, 1'b1, 1'b0};
        vecs[2] = '{6'd8,  7'd52, 32'h00101010, 1'b1, 1'b0};
        vecs[3] = '{6'd16, 7'd36, 32'h10102010, 1'b1, 1'b0};
        vecs[4] = '{6'd4,  7'd32, 32'h01020103, 1'b1, 1'b0};
        vecs[5] = '{6'd1,  7'd31, 32'h02040206, 1'b0, 1'b0};
        vecs[6] = '{6'd31, 7'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[7] = '{6'd0,  7'd0,  32'h00000000, 1'b0, 1'b0};
        vecs[8] = '{6'd1,  7'd0,  32'h00000000, 1'b0, 1'b1};
        vecs[9] = '{6'd0,  7'd0,  32'h00000000, 1'b0, 1'b1};

        Reset = 1'b1; start = 1'b0; enable = 1'b0; consume = 1'b0;
        consume_n = '0; base_address = '0; sb_en = 1'b0;
        repeat (3) step();
        check("rst_addr", 64'(SRAM_address), 64'd0);
        check("rst_fill", 64'(fill), 64'd0);
        check("rst_window", 64'(window), 64'd0);
        check("rst_valid", 64'(window_valid), 64'd0);
        check("rst_words", 64'(words_read), 64'd0);
        check("rst_uf", 64'(underflow_err), 64'd0);
        check("we_n", 64'(SRAM_we_n), 64'd1);
        Reset = 1'b0;

        // Idle: enable alone must not issue reads.
        enable = 1'b1;
        repeat (4) step();
        check("idle_addr", 64'(SRAM_address), 64'd0);
        check("idle_words", 64'(words_read), 64'd0);

        // Prime at 0x100 without consuming.
        do_start(18'h100);
        wait_valid("start_to_valid", 4);
        repeat (8) step();
        check("prime_fill64", 64'(fill), 64'd64);
        check("prime_window", 64'(window), 64'h01000101);
        check("prime_words", 64'(words_read), 64'd4);
        check("prime_addr", 64'(SRAM_address), 64'h104);
        check("prime_valid", 64'(window_valid), 64'd1);

        // Table of pure shifts with issue stalled.
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            consume = 1'b1;
            consume_n = vecs[i].n;
            step();
            consume = 1'b0;
            check($sformatf("vec%0d_fill", i), 64'(fill), 64'(vecs[i].exp_fill));
            check($sformatf("vec%0d_window", i), 64'(window), 64'(vecs[i].exp_win));
            check($sformatf("vec%0d_valid", i), 64'(window_valid), 64'(vecs[i].exp_vld));
            check($sformatf("vec%0d_uf", i), 64'(underflow_err), 64'(vecs[i].exp_uf));
        end

        // Sustained 16 bits per cycle.
        prime(18'h100);
        sb_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            consume = 1'b1;
            consume_n = 6'd16;
            sb_q.push_back(16'(32'h100 + k));
            step();
        end
        consume = 1'b0;
        sb_en = 1'b0;
        check("tp_drain", 64'(sb_q.size()), 64'd0);

        // Consume 5 with a full buffer: nothing can arrive.
        prime(18'h100);
        consume = 1'b1; consume_n = 6'd5;
        step();
        consume = 1'b0;
        check("c5_full_fill", 64'(fill), 64'd59);
        check("c5_full_window", 64'(window), 64'h20002020);
        step();
        check("c5_full_hold", 64'(fill), 64'd59);

        // Consume 5 in the same cycle that word 0x0104 lands, starting from fill 48.
        prime(18'h100);
        consume = 1'b1; consume_n = 6'd16;
        step();
        consume = 1'b0;
        check("c5_arr_fill48a", 64'(fill), 64'd48);
        step();
        check("c5_arr_fill48b", 64'(fill), 64'd48);
        consume = 1'b1; consume_n = 6'd5;
        step();
        consume = 1'b0;
        check("c5_arr_fill", 64'(fill), 64'd59);
        check("c5_arr_window", 64'(window), 64'h20202040);
        check("c5_arr_words", 64'(words_read), 64'd5);

        // Address wrap with enable 1,0,0,1.
        enable = 1'b1;
        do_start(18'h3FFFE);
        step();
        check("wrap_addr1", 64'(SRAM_address), 64'h3FFFF);
        enable = 1'b0;
        step();
        check("wrap_addr2", 64'(SRAM_address), 64'h3FFFF);
        check("wrap_words2", 64'(words_read), 64'd0);
        step();
        check("wrap_addr3", 64'(SRAM_address), 64'h3FFFF);
        check("wrap_words3", 64'(words_read), 64'd1);
        check("wrap_fill3", 64'(fill), 64'd16);
        check("wrap_window3", 64'(window), 64'hFFFE0000);
        enable = 1'b1;
        step();
        check("wrap_addr4", 64'(SRAM_address), 64'h00000);
        step();
        check("wrap_addr5", 64'(SRAM_address), 64'h00001);
        repeat (6) step();
        check("wrap_fill", 64'(fill), 64'd64);
        check("wrap_window", 64'(window), 64'hFFFEFFFF);
        check("wrap_words", 64'(words_read), 64'd4);
        check("wrap_addr_end", 64'(SRAM_address), 64'h00002);

        // Restart while two reads are in flight.
        enable = 1'b1;
        do_start(18'h100);
        step();
        step();
        do_start(18'h200);
        wait_valid("restart_to_valid", 4);
        check("restart_window", 64'(window), 64'h02000201);
        check("restart_words", 64'(words_read), 64'd2);

        // Underflow: consume 20 with fill 16.
        enable = 1'b1;
        do_start(18'h100);
        step();
        enable = 1'b0;
        step();
        step();
        check("uf_fill16", 64'(fill), 64'd16);
        consume = 1'b1; consume_n = 6'd20;
        step();
        consume = 1'b0;
        check("uf_fill", 64'(fill), 64'd0);
        check("uf_flag", 64'(underflow_err), 64'd1);
        check("uf_window", 64'(window), 64'd0);
        repeat (3) step();
        check("uf_sticky", 64'(underflow_err), 64'd1);
        enable = 1'b1;
        repeat (8) step();
        check("pre_reset_valid", 64'(window_valid), 64'd1);
        check("pre_reset_words", 64'(words_read), 64'd5);
        check("pre_reset_uf", 64'(underflow_err), 64'd1);

        // Reset mid-stream.
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("mrst_addr", 64'(SRAM_address), 64'd0);
        check("mrst_fill", 64'(fill), 64'd0);
        check("mrst_window", 64'(window), 64'd0);
        check("mrst_valid", 64'(window_valid), 64'd0);
        check("mrst_words", 64'(words_read), 64'd0);
        check("mrst_uf", 64'(underflow_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
